spi_slave_ctrl: RTL and testbench

// - SPI slave front end (mode 0, single clock domain) that sits directly upstream of the single-port RAM.
// - Deserialises MOSI frames into 10-bit {cmd[1:0], data[7:0]} words on rx_data/rx_valid for the RAM.
// - Serialises the RAM read byte (tx_data/tx_valid) back to the master on MISO.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_tx_shifter.sv | 54 +++++
 rtl/spi_slave_ctrl.sv | 103 ++++++++++
 tb/tb_spi_slave_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI slave shared definitions: FSM state encoding, command codes, width defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  localparam int RX_W_DEF = 10;
  localparam int TX_W_DEF = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WRITE     = 3'b001,
    CHK_CMD   = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } spi_state_e;

endpackage

// File: rtl/spi_tx_shifter.sv
// MISO serialiser: loads the RAM read byte, then shifts it out MSB first.
// Latency: first bit on MISO the cycle after the load edge, one bit per cycle for TX_W cycles.
// Backpressure: none; load waits indefinitely for tx_valid, abort (slave deselect) kills a read-out.
module spi_tx_shifter #(
  parameter int TX_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            tx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            abort,
  output logic            miso,
  output logic            done
);

  localparam int CW = $clog2(TX_W + 1);

  logic [TX_W-1:0] tx_shift;
  logic [CW-1:0]   tx_cnt;
  logic            busy;

  // Load once per frame, shift MSB first, then park MISO low with done held until deselect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      tx_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      miso     <= 1'b0;
    end else if (abort) begin
      tx_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      miso   <= 1'b0;
    end else if (busy) begin
      if (tx_cnt == CW'(TX_W)) begin
        busy <= 1'b0;
        done <= 1'b1;
        miso <= 1'b0;
      end else begin
        miso     <= tx_shift[TX_W-1];
        tx_shift <= tx_shift << 1;
        tx_cnt   <= tx_cnt + CW'(1);
      end
    end else if (load_en && tx_valid && !done) begin
      tx_shift <= tx_data;
      tx_cnt   <= '0;
      busy     <= 1'b1;
      miso     <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave front end: deserialises {cmd,data} words to the RAM, serialises read bytes back.
// Latency: rx_valid one cycle after the last payload bit; MISO starts the cycle after tx_valid.
// Backpressure: none; read data is awaited without bound, SS_n high aborts any frame.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int RX_W = RX_W_DEF,
  parameter int TX_W = TX_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            SS_n,
  input  logic            MOSI,
  output logic            MISO,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  localparam int CW = $clog2(RX_W + 1);

  spi_state_e      state;
  logic [CW-1:0]   rx_cnt;
  logic [RX_W-1:0] rx_shift;
  logic            rd_addr_seen;
  logic            frame_full;
  logic            tx_load_en;
  logic            tx_done;

  assign frame_full = (rx_cnt == CW'(RX_W));
  // Only a completed read-data frame may accept the RAM byte; stray tx_valid is ignored.
  assign tx_load_en = (state == READ_DATA) && frame_full && !SS_n;

  // Frame FSM, payload deserialiser and read-address tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_cnt       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A finished read-out consumes the stored read address.
      if (tx_done) begin
        rd_addr_seen <= 1'b0;
      end
      if (SS_n) begin
        state  <= IDLE;
        rx_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_cnt <= '0;
            if (!MOSI) begin
              state <= WRITE;
            end else if (rd_addr_seen) begin
              state <= READ_DATA;
            end else begin
              state <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Counter saturates at RX_W so trailing MOSI bits are ignored.
            if (!frame_full) begin
              rx_shift <= {rx_shift[RX_W-2:0], MOSI};
              rx_cnt   <= rx_cnt + CW'(1);
              if (rx_cnt == CW'(RX_W - 1)) begin
                rx_valid <= 1'b1;
                rx_data  <= {rx_shift[RX_W-2:0], MOSI};
                if (state == READ_ADD) begin
                  rd_addr_seen <= 1'b1;
                end
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  spi_tx_shifter #(
    .TX_W (TX_W)
  ) u_tx_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (tx_load_en),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .abort    (SS_n),
    .miso     (MISO),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: drives SPI frames and RAM read bytes, scoreboards rx_data words.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1ns after the rising edge.
// Every expected rx word is queued when its frame is driven and popped when rx_valid fires.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int total = 0;
  int bad = 0;
  logic [9:0] sb_q[$];

  spi_slave_ctrl #(
    .RX_W (10),
    .TX_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every rx_valid strobe must match the oldest queued word.
  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) begin
      check("rx_expected", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        check("rx_data", 32'(rx_data), 32'(sb_q.pop_front()));
      end
    end
  end

  // sel: select bit; nbits: payload bits sent before any deselect; stray: pulse tx_valid mid-frame;
  // keep_ss: leave SS_n low afterwards (used before a read-out).
  task automatic send_frame(input logic sel, input logic [9:0] pl, input int nbits,
                            input bit stray, input bit keep_ss);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = 1'b0;
    @(negedge clk);
    MOSI = sel;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      check("miso_quiet", 32'(MISO), 32'd0);
      check("rx_early", 32'(rx_valid), 32'd0);
      MOSI = pl[9-i];
      if (stray && i == 4) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    end
    if (nbits == 10) begin
      sb_q.push_back(pl);
      @(posedge clk);
      #1;
      check("rx_latency", 32'(rx_valid), 32'd1);
      @(posedge clk);
      #1;
      check("rx_pulse", 32'(rx_valid), 32'd0);
    end
    if (!keep_ss) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(negedge clk);
      check("frame_idle", 32'(dut.state), 32'(IDLE));
      check("miso_after", 32'(MISO), 32'd0);
    end
  endtask

  // mode 0: full byte; mode 1: deselect after 3 bits; mode 2: reset after 3 bits.
  task automatic read_byte(input logic [7:0] b, input int mode);
    int nbits;
    check("rd_state", 32'(dut.state), 32'(READ_DATA));
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("miso_load", 32'(MISO), 32'd0);
    nbits = (mode == 0) ? 8 : 3;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      check("miso_bit", 32'(MISO), 32'(b[7-i]));
    end
    if (mode == 0) begin
      @(negedge clk);
      check("miso_end", 32'(MISO), 32'd0);
      @(negedge clk);
      check("rd_seen_clr", 32'(dut.rd_addr_seen), 32'd0);
      SS_n = 1'b1;
      @(negedge clk);
      check("rd_idle", 32'(dut.state), 32'(IDLE));
    end else if (mode == 1) begin
      SS_n = 1'b1;
      @(negedge clk);
      check("miso_abort", 32'(MISO), 32'd0);
      check("rd_seen_keep", 32'(dut.rd_addr_seen), 32'd1);
      check("abort_idle", 32'(dut.state), 32'(IDLE));
    end else begin
      rst_n = 1'b0;
      #1;
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h000);
      check("rst_state", 32'(dut.state), 32'(IDLE));
      check("rst_rd_seen", 32'(dut.rd_addr_seen), 32'd0);
      @(negedge clk);
      SS_n  = 1'b1;
      rst_n = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("init_miso", 32'(MISO), 32'd0);
    check("init_rx_valid", 32'(rx_valid), 32'd0);
    check("init_rx_data", 32'(rx_data), 32'h000);
    check("init_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Write address then write data.
    send_frame(1'b0, 10'b00_1010_0101, 10, 1'b0, 1'b0);
    send_frame(1'b0, 10'b01_0011_1100, 10, 1'b0, 1'b0);

    // Deselect after 5 payload bits: nothing delivered, old word held.
    send_frame(1'b0, 10'h3FF, 5, 1'b0, 1'b0);
    check("abort_rx_data", 32'(rx_data), 32'h13C);

    // Read address then read data with a full byte return.
    send_frame(1'b1, 10'h207, 10, 1'b0, 1'b0);
    check("rd_seen_set", 32'(dut.rd_addr_seen), 32'd1);
    send_frame(1'b1, 10'h300, 10, 1'b0, 1'b1);
    read_byte(8'hC3, 0);

    // Read-out aborted after 3 bits, then retried in full.
    send_frame(1'b1, 10'h211, 10, 1'b0, 1'b0);
    send_frame(1'b1, 10'h300, 10, 1'b0, 1'b1);
    read_byte(8'h5A, 1);
    send_frame(1'b1, 10'h300, 10, 1'b0, 1'b1);
    read_byte(8'h5A, 0);

    // Stray tx_valid during a write frame.
    send_frame(1'b0, 10'h0F0, 10, 1'b1, 1'b0);
    check("stray_rx_data", 32'(rx_data), 32'h0F0);

    // Reset in the middle of a read-out.
    send_frame(1'b1, 10'h2A6, 10, 1'b0, 1'b0);
    send_frame(1'b1, 10'h300, 10, 1'b0, 1'b1);
    read_byte(8'h96, 2);
    repeat (2) @(negedge clk);
    check("post_rst_miso", 32'(MISO), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
